// File: rtl/axis_pkt_gen_if.sv
// axis_pkt_gen_if: AXI-Stream bundle between the packet generator and its sink.
interface axis_pkt_gen_if #(
   parameter int unsigned DATA_BYTES = 64
);
   logic                    tvalid;
   logic                    tready;
   logic [8*DATA_BYTES-1:0] tdata;
   logic [DATA_BYTES-1:0]   tkeep;
   logic                    tlast;
   modport master (output tvalid, tdata, tkeep, tlast, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream packet generator with programmable count, length and gap.
// Byte n of packet p carries (n ^ p)[7:0]; unused lanes of the final beat are zero.
module axis_pkt_gen #(
   parameter int unsigned DATA_BYTES = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cfg_start,
   input  logic           cfg_stop,
   input  logic [31:0]    cfg_num_pkts,
   input  logic [15:0]    cfg_pkt_len,
   input  logic [7:0]     cfg_gap,
   axis_pkt_gen_if.master m_axis,
   output logic           busy,
   output logic           done,
   output logic [31:0]    pkts_sent,
   output logic [47:0]    bytes_sent
);
   localparam logic [31:0] DB = 32'(DATA_BYTES);
   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
   state_t                  r_state;
   logic [31:0]             r_num;
   logic [15:0]             r_len;
   logic [15:0]             r_beat;
   logic [7:0]              r_gap;
   logic [7:0]              r_gap_cnt;
   logic                    r_stop;
   logic                    w_cfg;
   logic                    w_accept;
   logic                    w_last;
   logic [15:0]             w_len;
   logic [15:0]             w_k;
   logic [31:0]             w_p;
   logic [31:0]             w_rem;
   logic [DATA_BYTES-1:0]   w_keep;
   logic [8*DATA_BYTES-1:0] w_data;
   // Next beat to present: first beat of a new run, next beat of this packet, or first beat of the next one.
   always_comb begin
      w_cfg    = r_state == IDLE || r_state == DONE;
      w_accept = m_axis.tvalid && m_axis.tready;
      w_len    = w_cfg ? ((cfg_pkt_len == 16'd0) ? 16'd1 : cfg_pkt_len) : r_len;
      w_p      = w_cfg ? 32'd0 : (r_state == SEND && m_axis.tlast) ? pkts_sent + 32'd1 : pkts_sent;
      w_k      = (r_state == SEND && !m_axis.tlast) ? r_beat + 16'd1 : 16'd0;
      w_last   = (32'(w_k) + 32'd1) * DB >= 32'(w_len);
      w_rem    = 32'(w_len) % DB;
      w_keep   = '0;
      w_data   = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         w_keep[i]      = !w_last || w_rem == 32'd0 || 32'(i) < w_rem;
         w_data[8*i +: 8] = w_keep[i] ? 8'(32'(w_k) * DB + 32'(i)) ^ w_p[7:0] : 8'd0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_num      <= '0;
         r_len      <= '0;
         r_beat     <= '0;
         r_gap      <= '0;
         r_gap_cnt  <= '0;
         r_stop     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pkts_sent  <= '0;
         bytes_sent <= '0;
         {m_axis.tvalid, m_axis.tlast, m_axis.tkeep, m_axis.tdata} <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: if (cfg_start && !cfg_stop) begin
               r_num      <= cfg_num_pkts;
               r_len      <= w_len;
               r_gap      <= cfg_gap;
               r_stop     <= 1'b0;
               r_beat     <= '0;
               pkts_sent  <= '0;
               bytes_sent <= '0;
               if (cfg_num_pkts == 32'd0) begin
                  r_state <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  r_state <= SEND;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  {m_axis.tvalid, m_axis.tlast, m_axis.tkeep, m_axis.tdata} <= {1'b1, w_last, w_keep, w_data};
               end
            end
            SEND: begin
               if (cfg_stop) r_stop <= 1'b1;
               if (w_accept) begin
                  bytes_sent <= bytes_sent + 48'($countones(m_axis.tkeep));
                  if (!m_axis.tlast) begin
                     r_beat <= w_k;
                     {m_axis.tvalid, m_axis.tlast, m_axis.tkeep, m_axis.tdata} <= {1'b1, w_last, w_keep, w_data};
                  end else begin
                     pkts_sent <= pkts_sent + 32'd1;
                     r_beat    <= '0;
                     if (pkts_sent + 32'd1 == r_num || r_stop || cfg_stop) begin
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        {m_axis.tvalid, m_axis.tlast, m_axis.tkeep, m_axis.tdata} <= '0;
                     end else if (r_gap != 8'd0) begin
                        r_state   <= GAP;
                        r_gap_cnt <= r_gap;
                        {m_axis.tvalid, m_axis.tlast, m_axis.tkeep, m_axis.tdata} <= '0;
                     end else
                        {m_axis.tvalid, m_axis.tlast, m_axis.tkeep, m_axis.tdata} <= {1'b1, w_last, w_keep, w_data};
                  end
               end
            end
            GAP: if (cfg_stop) begin
               r_state <= DONE;
               busy    <= 1'b0;
               done    <= 1'b1;
            end else if (r_gap_cnt == 8'd1) begin
               r_state <= SEND;
               {m_axis.tvalid, m_axis.tlast, m_axis.tkeep, m_axis.tdata} <= {1'b1, w_last, w_keep, w_data};
            end else
               r_gap_cnt <= r_gap_cnt - 8'd1;
         endcase
      end
   end
endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: directed scenarios against a byte-stream model of the generator,
// checked every cycle by one compare process plus hand-computed run totals.
module tb_axis_pkt_gen;
   localparam int DB = 64;
   typedef struct packed {
      logic [8*DB-1:0] d;
      logic [DB-1:0]   k;
      logic            l;
   } beat_t;
   logic            clk = 0;
   logic            rst_n = 0;
   logic            cfg_start = 0;
   logic            cfg_stop = 0;
   logic [31:0]     cfg_num_pkts = 0;
   logic [15:0]     cfg_pkt_len = 0;
   logic [7:0]      cfg_gap = 0;
   logic            busy;
   logic            done;
   logic [31:0]     pkts_sent;
   logic [47:0]     bytes_sent;
   int              checks = 0;
   int              errors = 0;
   beat_t           q[$];
   beat_t           e;
   logic [31:0]     m_pkts = 0;
   logic [31:0]     m_end = 0;
   logic [47:0]     m_bytes = 0;
   logic            m_busy = 0;
   logic            m_done = 0;
   int              m_gap = 0;
   int              gap_run = -1;
   int              last_gap = -1;
   logic [8*DB-1:0] last_d = 0;
   logic [DB-1:0]   last_k = 0;
   logic            rand_rdy = 0;
   logic            pv = 0;
   logic            pr = 0;
   logic            pl = 0;
   logic [8*DB-1:0] pd = 0;
   logic [DB-1:0]   pk = 0;

   axis_pkt_gen_if #(.DATA_BYTES(DB)) axis ();
   axis_pkt_gen #(.DATA_BYTES(DB)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_num_pkts(cfg_num_pkts), .cfg_pkt_len(cfg_pkt_len), .cfg_gap(cfg_gap),
      .m_axis(axis), .busy(busy), .done(done), .pkts_sent(pkts_sent), .bytes_sent(bytes_sent)
   );

   always #5 clk = ~clk;
   always @(posedge clk) begin
      #1;
      axis.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected stream as a flat byte sequence per packet, cut into beats.
   task automatic build(input int num, input int len);
      beat_t b;
      int l = (len == 0) ? 1 : len;
      q.delete();
      for (int p = 0; p < num; p++) begin
         b = '0;
         for (int x = 0; x < l; x++) begin
            b.d[8*(x%DB) +: 8] = 8'(x ^ p);
            b.k[x%DB] = 1'b1;
            b.l = (x == l - 1);
            if (x % DB == DB - 1 || x == l - 1) begin
               q.push_back(b);
               b = '0;
            end
         end
      end
   endtask

   task automatic start(input int num, input int len, input int gap);
      @(posedge clk);
      #1;
      cfg_num_pkts = num;
      cfg_pkt_len  = 16'(len);
      cfg_gap      = 8'(gap);
      cfg_start    = 1;
      @(posedge clk);
      #1;
      cfg_start = 0;
      build(num, len);
      m_pkts = 0;
      m_bytes = 0;
      m_end = num;
      m_gap = gap;
      gap_run = -1;
      last_gap = -1;
      m_busy = (num != 0);
      m_done = (num == 0);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk({name, " done"}, done, 1);
   endtask

   task automatic pulse_stop_after(input int cycles);
      repeat (cycles) @(posedge clk);
      #1 cfg_stop = 1;
      @(posedge clk);
      #1 cfg_stop = 0;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, " tvalid"}, axis.tvalid, 0);
      chk({name, " tlast"}, axis.tlast, 0);
      chk({name, " tkeep"}, axis.tkeep, 0);
      chk({name, " tdata"}, axis.tdata, 0);
      chk({name, " busy"}, busy, 0);
      chk({name, " done"}, done, 0);
      chk({name, " pkts_sent"}, pkts_sent, 0);
      chk({name, " bytes_sent"}, bytes_sent, 0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("pkts_sent", pkts_sent, m_pkts);
         chk("bytes_sent", bytes_sent, m_bytes);
         if (pv && !pr) begin
            chk("hold tvalid", axis.tvalid, 1);
            chk("hold tdata", axis.tdata, pd);
            chk("hold tkeep", axis.tkeep, pk);
            chk("hold tlast", axis.tlast, pl);
         end
         if (gap_run >= 0) begin
            if (!axis.tvalid) gap_run++;
            else begin
               chk("gap length", gap_run, m_gap);
               last_gap = gap_run;
               gap_run = -1;
            end
         end
         if (cfg_stop && m_busy) begin
            if (axis.tvalid) m_end = m_pkts + 1;
            else begin
               m_busy = 0;
               m_done = 1;
               gap_run = -1;
            end
         end
         if (axis.tvalid) begin
            if (!m_busy || q.size() == 0) chk("unexpected tvalid", axis.tvalid, 0);
            else if (axis.tready) begin
               e = q.pop_front();
               chk("tdata", axis.tdata, e.d);
               chk("tkeep", axis.tkeep, e.k);
               chk("tlast", axis.tlast, e.l);
               m_bytes += 48'($countones(e.k));
               last_d = axis.tdata;
               last_k = axis.tkeep;
               if (e.l) begin
                  m_pkts++;
                  if (m_pkts == m_end) begin
                     m_busy = 0;
                     m_done = 1;
                  end else gap_run = 0;
               end
            end
         end else if (m_busy && gap_run < 0) chk("tvalid while sending", axis.tvalid, 1);
         pv = axis.tvalid;
         pr = axis.tready;
         pd = axis.tdata;
         pk = axis.tkeep;
         pl = axis.tlast;
      end else pv = 0;
   end

   initial begin
      #12;
      chk_all_zero("reset");
      @(posedge clk);
      #3 rst_n = 1;
      repeat (2) @(posedge clk);

      start(3, 128, 0);
      wait_done("s1");
      chk("s1 pkts", pkts_sent, 3);
      chk("s1 bytes", bytes_sent, 384);
      chk("s1 beats left", q.size(), 0);

      start(1, 65, 0);
      wait_done("len65");
      chk("len65 bytes", bytes_sent, 65);
      chk("len65 last tkeep", last_k, 64'h1);
      chk("len65 last tdata", last_d, 512'h40);

      start(1, 0, 0);
      wait_done("len0");
      chk("len0 bytes", bytes_sent, 1);
      chk("len0 tkeep", last_k, 64'h1);

      start(2, 64, 3);
      wait_done("gap3");
      chk("gap3 low cycles", last_gap, 3);
      chk("gap3 pkts", pkts_sent, 2);

      start(0, 64, 0);
      wait_done("zero");
      chk("zero pkts", pkts_sent, 0);

      rand_rdy = 1;
      start(10, 200, 0);
      repeat (3) @(posedge clk);
      #1 cfg_start = 1;
      cfg_num_pkts = 1;
      @(posedge clk);
      #1 cfg_start = 0;
      wait_done("rand");
      rand_rdy = 0;
      chk("rand pkts", pkts_sent, 10);
      chk("rand bytes", bytes_sent, 2000);

      start(5, 256, 0);
      pulse_stop_after(5);
      wait_done("stop send");
      chk("stop send pkts", pkts_sent, 2);
      chk("stop send bytes", bytes_sent, 512);

      @(posedge clk);
      #1 cfg_start = 1;
      cfg_stop = 1;
      cfg_num_pkts = 4;
      @(posedge clk);
      #1 cfg_start = 0;
      cfg_stop = 0;
      repeat (2) @(negedge clk);
      chk("start+stop done", done, 1);
      chk("start+stop busy", busy, 0);
      chk("start+stop pkts", pkts_sent, 2);

      start(3, 64, 5);
      pulse_stop_after(3);
      wait_done("stop gap");
      chk("stop gap pkts", pkts_sent, 1);
      chk("stop gap bytes", bytes_sent, 64);

      start(2, 256, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 0;
      m_busy = 0;
      m_done = 0;
      m_pkts = 0;
      m_bytes = 0;
      gap_run = -1;
      q.delete();
      #1;
      chk_all_zero("async reset");
      repeat (3) @(posedge clk);
      #3 rst_n = 1;
      repeat (5) @(negedge clk);
      chk("post reset tvalid", axis.tvalid, 0);
      chk("post reset busy", busy, 0);

      start(1, 64, 0);
      wait_done("after reset");
      chk("after reset pkts", pkts_sent, 1);
      chk("after reset bytes", bytes_sent, 64);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 64, meaning the stream width in bytes; data width is 8*DATA_BYTES and keep width is DATA_BYTES.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-004 SHALL have port cfg_start, input, 1, a single-cycle request to begin a run.
REQ-005 SHALL have port cfg_stop, input, 1, a request to end the run after the current packet.
REQ-006 SHALL have port cfg_num_pkts, input, 32, the number of packets per run.
REQ-007 SHALL have port cfg_pkt_len, input, 16, the packet length in bytes.
REQ-008 SHALL have port cfg_gap, input, 8, the number of idle cycles between packets.
REQ-009 SHALL have port tvalid, output, 1, the stream valid.
REQ-010 SHALL have port tready, input, 1, the downstream ready.
REQ-011 SHALL have port tdata, output, 8*DATA_BYTES, the stream data.
REQ-012 SHALL have port tkeep, output, DATA_BYTES, the byte enables.
REQ-013 SHALL have port tlast, output, 1, marking the final beat of a packet.
REQ-014 SHALL have port busy, output, 1, high while a run is in progress.
REQ-015 SHALL have port done, output, 1, a level held high once a run has finished.
REQ-016 SHALL have port pkts_sent, output, 32, the number of packets accepted in the current run.
REQ-017 SHALL have port bytes_sent, output, 48, the number of bytes accepted in the current run (sum of tkeep bits on accepted beats).

Function
REQ-018 SHALL implement FSM states IDLE, SEND, GAP, DONE; reset state is IDLE.
REQ-019 SHALL, on cfg_start in IDLE or DONE:
- latch cfg_num_pkts, cfg_pkt_len and cfg_gap;
- clear pkts_sent, bytes_sent and done;
- enter SEND, or go directly to DONE if the latched num_pkts is 0.
REQ-020 SHALL ignore cfg_start while in SEND or GAP.
REQ-021 SHALL treat a latched pkt_len of 0 as 1.
REQ-022 SHALL assert tvalid in the first cycle after cfg_start is sampled; start-to-valid latency is 1 cycle.
REQ-023 SHALL define a beat as accepted when tvalid and tready are both high at posedge clk.
REQ-024 SHALL hold tvalid, tdata, tkeep and tlast stable from assertion of tvalid until the beat is accepted.
REQ-025 SHALL not deassert tvalid before the beat is accepted.
REQ-026 SHALL size each packet at B = ceil(len/DATA_BYTES) beats.
REQ-027 SHALL drive tkeep all-ones on beats 0..B-2.
REQ-028 SHALL drive tkeep on beat B-1 with the low (len mod DATA_BYTES) bits set, or all-ones when that remainder is 0.
REQ-029 SHALL assert tlast only on beat B-1.
REQ-030 SHALL drive byte lane i of beat k of packet p with ((k*DATA_BYTES + i) XOR p)[7:0].
REQ-031 SHALL drive lanes whose tkeep bit is 0 with 0.
REQ-032 SHALL, on each accepted beat, add popcount(tkeep) to bytes_sent.
REQ-033 SHALL, on each accepted tlast beat, increment pkts_sent.
REQ-034 SHALL, after an accepted tlast beat, go to DONE with tvalid low in the next cycle if pkts_sent+1 equals num_pkts or a stop is pending.
REQ-035 SHALL otherwise, after an accepted tlast beat, enter GAP when gap>0 and hold tvalid low for exactly gap cycles before returning to SEND.
REQ-036 SHALL otherwise, after an accepted tlast beat with gap=0, present the first beat of the next packet in the next cycle with no bubble.
REQ-037 SHALL register a cfg_stop pulse seen in SEND as a pending stop, so the current packet completes normally.
REQ-038 SHALL go to DONE immediately on cfg_stop in GAP.
REQ-039 SHALL ignore cfg_stop in IDLE and DONE.
REQ-040 SHALL give cfg_stop priority over cfg_start when both are high in the same cycle.
REQ-041 SHALL drive busy = (state is SEND or GAP).
REQ-042 SHALL drive done = (state is DONE).
REQ-043 SHALL let pkts_sent and bytes_sent wrap modulo 2^32 and 2^48 without flagging.

Reset
REQ-044 SHALL, while rst_n is low, force tvalid, tlast, busy and done to 0.
REQ-045 SHALL, while rst_n is low, force tkeep, tdata, pkts_sent and bytes_sent to 0.
REQ-046 SHALL, while rst_n is low, force the FSM to IDLE and clear all latched config and the pending stop.
REQ-047 SHALL abandon a partial packet when reset asserts mid-packet; no tlast is emitted for it.
REQ-048 SHALL remain in IDLE after rst_n deasserts until the next cfg_start.

Verification
REQ-049 SHALL be covered by scenario: num_pkts=3, len=128, gap=0, tready=1 -> 6 contiguous valid beats, tlast on beats 1/3/5, pkts_sent=3, bytes_sent=384, done high 1 cycle after last beat.
REQ-050 SHALL be covered by scenario: num_pkts=1, len=65 -> 2 beats; beat 1 tkeep=64'h1, bytes_sent=65; len=0 -> 1 beat, tkeep=64'h1.
REQ-051 SHALL be covered by scenario: num_pkts=2, len=64, gap=3 -> exactly 3 tvalid-low cycles between the two tlast beats.
REQ-052 SHALL be covered by scenario: random tready (50%) with num_pkts=10, len=200 -> held beats unchanged while stalled, pkts_sent=10, bytes_sent=2000.
REQ-053 SHALL be covered by scenario: cfg_stop on beat 1 of packet 2 of 5 (len=256) -> packet 2 completes with 4 beats, pkts_sent=2, done=1.
REQ-054 SHALL be covered by scenario: rst_n low mid-packet -> all outputs 0 asynchronously, IDLE after release, no tvalid until cfg_start.
